// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter: widths, requester IDs, write record.
package rf_pkg;

  localparam int unsigned RF_XLEN = 32;
  localparam int unsigned RF_AW   = 5;

  localparam logic RF_REQ_EXE = 1'b0;
  localparam logic RF_REQ_LD  = 1'b1;

  typedef struct packed {
    logic [RF_AW-1:0]   addr;
    logic [RF_XLEN-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_arb_pick.sv
// Combinational 2-way grant picker. RF_ARB_RR_EN selects round-robin; otherwise req1 has
// fixed priority over req0.
module rf_arb_pick
  import rf_pkg::*;
(
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  input  logic hold_i,
  output logic gnt0_o,
  output logic gnt1_o
);

`ifndef RF_ARB_RR_EN
  // Fixed priority never consults the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (!hold_i) begin
      if (valid0_i && valid1_i) begin
`ifdef RF_ARB_RR_EN
        if (last_grant_i == RF_REQ_EXE) begin
          gnt1_o = 1'b1;
        end else begin
          gnt0_o = 1'b1;
        end
`else
        gnt1_o = 1'b1;
`endif
      end else begin
        gnt0_o = valid0_i;
        gnt1_o = valid1_i;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register-file write port between execute (req0) and load (req1) writebacks
// through a one-deep commit stage. Define RF_ARB_RR_EN for round-robin arbitration.
module regfile_wr_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN,
  parameter int unsigned AW   = RF_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [AW-1:0]       req0_addr_i,
  input  logic [XLEN-1:0]     req0_data_i,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [AW-1:0]       req1_addr_i,
  input  logic [XLEN-1:0]     req1_data_i,
  input  logic                hold_i,
  output logic                rf_write_o,
  output logic [AW-1:0]       rf_wraddr_o,
  output logic [XLEN-1:0]     rf_wrdata_o,
  output logic [(2**AW)-1:0]  pend_mask_o,
  output logic                last_grant_o
);

  logic            rf_write_d, rf_write_q;
  logic [AW-1:0]   wraddr_d, wraddr_q;
  logic [XLEN-1:0] wrdata_d, wrdata_q;
  logic            last_grant_d, last_grant_q;
  logic            acc0, acc1;

  rf_arb_pick u_pick (
    .valid0_i     (req0_valid_i),
    .valid1_i     (req1_valid_i),
    .last_grant_i (last_grant_q),
    .hold_i       (hold_i),
    .gnt0_o       (req0_ready_o),
    .gnt1_o       (req1_ready_o)
  );

  assign acc0 = req0_valid_i && req0_ready_o;
  assign acc1 = req1_valid_i && req1_ready_o;

  always_comb begin
    rf_write_d   = 1'b0;
    wraddr_d     = wraddr_q;
    wrdata_d     = wrdata_q;
    last_grant_d = last_grant_q;
    // Address 0 is still accepted and loaded, only the write enable is suppressed.
    if (acc1) begin
      rf_write_d   = |req1_addr_i;
      wraddr_d     = req1_addr_i;
      wrdata_d     = req1_data_i;
      last_grant_d = RF_REQ_LD;
    end else if (acc0) begin
      rf_write_d   = |req0_addr_i;
      wraddr_d     = req0_addr_i;
      wrdata_d     = req0_data_i;
      last_grant_d = RF_REQ_EXE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_q   <= 1'b0;
      wraddr_q     <= '0;
      wrdata_q     <= '0;
      last_grant_q <= RF_REQ_LD;
    end else begin
      rf_write_q   <= rf_write_d;
      wraddr_q     <= wraddr_d;
      wrdata_q     <= wrdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    pend_mask_o = '0;
    if (rf_write_q) begin
      pend_mask_o[wraddr_q] = 1'b1;
    end
  end

  assign rf_write_o   = rf_write_q;
  assign rf_wraddr_o  = wraddr_q;
  assign rf_wrdata_o  = wrdata_q;
  assign last_grant_o = last_grant_q;

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Arbitrates the single write port of the 32x32 register file between two writeback sources: req0 is the ALU/execute writeback and req1 is the load/memory writeback. It grants at most one request per cycle using a valid/ready handshake and registers the winner into a one-deep commit stage that drives the register file write port. It also exports a pending-write mask so the decode stage can detect read-after-write hazards against in-flight writes.

## Interface
- `XLEN`, default 32: data width.
- `AW`, default 5: register address width. The file has 2^AW entries.
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `req0_valid`, input, 1: execute writeback request.
- `req0_ready`, output, 1: grant to req0, combinational.
- `req0_addr`, input, AW: destination register for req0.
- `req0_data`, input, XLEN: write data for req0.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as req0, for the load writeback.
- `hold`, input, 1: when 1, no new grants are issued; the commit stage still drains.
- `rf_write`, output, 1: write enable to the register file. Registered.
- `rf_wraddr`, output, AW: write address to the register file. Registered.
- `rf_wrdata`, output, XLEN: write data to the register file. Registered.
- `pend_mask`, output, 2^AW: one-hot of `rf_wraddr` when `rf_write`=1, otherwise all zeros.
- `last_grant`, output, 1: ID of the most recent accepted request (0 or 1). Registered.

## Operation
- A request is accepted when `reqN_valid` and `reqN_ready` are both 1 in the same cycle.
- Requesters hold `addr`/`data` stable while valid=1 and not yet accepted. They must not drop valid before acceptance.
- `reqN_ready` = `!hold` and (only N is valid, or N wins arbitration). Ready is 0 when hold=1 or when N is not the winner.
- Arbitration when both requests are valid is set by the configuration macro (see Configuration).
- On acceptance:
  - the commit stage loads addr/data;
  - `rf_write` is set to 1 if the address is nonzero;
  - a request to address 0 is accepted but `rf_write` is 0, so writes to x0 are dropped;
  - `last_grant` is updated to the ID of the accepted request.
- With no acceptance in a cycle, `rf_write` is 0 in the next cycle. `rf_wraddr` and `rf_wrdata` keep their last values.
- The commit stage never stalls, because the register file accepts a write every cycle. Back-to-back grants are therefore allowed every cycle.
- Two consecutive grants to the same address are committed in grant order; the last one wins.

## Timing
- Reset values (async, `rst_n`=0): `rf_write`=0, `rf_wraddr`=0, `rf_wrdata`=0, `last_grant`=1 (so req0 wins first under round-robin), `pend_mask`=0.
- Latency:
  - request accepted in cycle N;
  - `rf_write`, `rf_wraddr` and `rf_wrdata` are valid in cycle N+1;
  - the register file is updated at the end of N+1;
  - the data is readable from the register file in cycle N+2.
- `pend_mask` covers cycle N+1 only. Decode must stall or forward on a hit.
- `hold` takes effect combinationally in the same cycle. An in-flight commit completes regardless of hold.
- Reset asserted mid-operation: the commit stage is cleared immediately and an in-flight write is lost. Requesters re-present after reset.
- Throughput: one write per cycle. The sustained grant ratio with both requesters valid is 1:1 under round-robin.

## Configuration
- Macro `RF_ARB_RR_EN`.
- Defined: round-robin arbitration. When both requests are valid, the winner is the ID opposite `last_grant`.
- Undefined: fixed priority, req1 (load) always wins. req0 is granted only when req1 is not valid. `last_grant` is still maintained.

## Structure
- Shared package `rf_pkg` holds:
  - `XLEN` and `AW` constants;
  - requester ID constants `RF_REQ_EXE`=0 and `RF_REQ_LD`=1;
  - a packed struct `rf_wr_t` {addr, data}.
- One sub-module, `rf_arb_pick`: a combinational 2-way picker. Inputs are the two valids, `last_grant` and `hold`; outputs are the two grants.
- The commit register, x0 filter and `pend_mask` decode live in the top module.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `rf_write`=1 → all outputs read 0 immediately, and `last_grant`=1.
- Single requester: req0 valid, addr 5, data 0xDEADBEEF, at cycle N → `req0_ready`=1 at N; `rf_write`=1, `rf_wraddr`=5, `pend_mask`=0x20 at N+1; reading register 5 returns 0xDEADBEEF at N+2.
- x0 drop: req1 valid to addr 0, data 0x1234 → `req1_ready`=1; `rf_write`=0 at N+1; register 0 still reads 0.
- Contention with `RF_ARB_RR_EN` defined: both valid for 4 cycles → grant sequence 0,1,0,1.
- Contention with `RF_ARB_RR_EN` undefined: both valid for 4 cycles → grant sequence 1,1,1,1.
- Hold: hold=1 for 3 cycles with both valid → both ready=0 and no new `rf_write`. Release hold → grants resume the next cycle, and the data written matches the stable request values.
